// File: rtl/tt_micro_cnt_checker.sv
// -----------------------------------------------------------------------------
// tt_micro_cnt_checker
//
// Purpose: downstream monitor for a micro-tile output bus. It checks that the
// bus carries a free-running up-counter (each sample == previous sample + 1,
// modulo 2^WIDTH) and reports lock, mismatch and a saturating error count.
//
// Optional feature: define CHECKER_STICKY_FAIL_EN to make a mismatch while
// locked enter a sticky FAIL state. FAIL is released by clr or en=0. Without
// the macro, fail is a one-cycle pulse and the checker re-locks by itself.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   en         monitoring enable; low returns to IDLE on the next edge
//   clr        synchronous clear of err_cnt (and of the sticky fail)
//   din        monitored bus
//   locked     high while in LOCK
//   fail       mismatch indication (pulse, or sticky with the macro)
//   err_cnt    mismatches seen while locked, saturating at 255
//   last_good  most recent din accepted as a valid increment while locked
// -----------------------------------------------------------------------------
module tt_micro_cnt_checker #(
    parameter int WIDTH    = 8,
    parameter int LOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic             locked,
    output logic             fail,
    output logic [7:0]       err_cnt,
    output logic [WIDTH-1:0] last_good
);

    localparam int RUN_W = $clog2(LOCK_CNT + 1);
    localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(LOCK_CNT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        LOCK = 2'd2,
        FAIL = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             locked_q, locked_d;
    logic             fail_q, fail_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic [WIDTH-1:0] last_good_q, last_good_d;

    logic [WIDTH-1:0] prev_inc;
    logic [RUN_W-1:0] run_inc;
    logic             match;
    logic             lock_miss;

    // Saturating increment for the error counter.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // The increment is held in a WIDTH-bit net so the wrap (max -> 0) is a
    // match; comparing against an unsized "prev + 1" would widen to 32 bits.
    assign prev_inc = prev_q + WIDTH'(1);
    assign run_inc  = run_q + RUN_W'(1);
    assign match    = (din == prev_inc);

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        run_d       = run_q;
        last_good_d = last_good_q;
        lock_miss   = 1'b0;

        if (!en) begin
            // Dropping en abandons monitoring; no comparison is made.
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SYNC;
                    prev_d  = din;
                    run_d   = '0;
                end
                SYNC: begin
                    prev_d = din;
                    if (match) begin
                        if (run_inc == RUN_LOCK) begin
                            state_d = LOCK;
                            run_d   = '0;
                        end else begin
                            run_d = run_inc;
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                LOCK: begin
                    prev_d = din;
                    if (match) begin
                        last_good_d = din;
                    end else begin
                        lock_miss = 1'b1;
                        run_d     = '0;
`ifdef CHECKER_STICKY_FAIL_EN
                        state_d   = FAIL;
`else
                        // The bad sample is now prev, so re-lock starts here.
                        state_d   = SYNC;
`endif
                    end
                end
`ifdef CHECKER_STICKY_FAIL_EN
                FAIL: begin
                    prev_d = din;
                    if (clr) begin
                        state_d = SYNC;
                        run_d   = '0;
                    end
                end
`endif
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // clr wins over a simultaneous increment.
        if (clr) begin
            err_cnt_d = 8'd0;
        end else if (lock_miss) begin
            err_cnt_d = sat_inc(err_cnt_q);
        end else begin
            err_cnt_d = err_cnt_q;
        end

        locked_d = (state_d == LOCK);
`ifdef CHECKER_STICKY_FAIL_EN
        fail_d = (state_d == FAIL);
`else
        fail_d = lock_miss;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            prev_q      <= '0;
            run_q       <= '0;
            locked_q    <= 1'b0;
            fail_q      <= 1'b0;
            err_cnt_q   <= 8'd0;
            last_good_q <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            run_q       <= run_d;
            locked_q    <= locked_d;
            fail_q      <= fail_d;
            err_cnt_q   <= err_cnt_d;
            last_good_q <= last_good_d;
        end
    end

    assign locked    = locked_q;
    assign fail      = fail_q;
    assign err_cnt   = err_cnt_q;
    assign last_good = last_good_q;

endmodule

// File: tb/tb_tt_micro_cnt_checker.sv
// -----------------------------------------------------------------------------
// tb_tt_micro_cnt_checker
//
// Self-checking bench for tt_micro_cnt_checker in its default build (sticky
// fail disabled). A table of {inputs, expected outputs} records is applied one
// clock at a time; hand-written sequences cover saturation, clr versus a
// simultaneous mismatch, and asynchronous reset mid-lock.
// -----------------------------------------------------------------------------
module tb_tt_micro_cnt_checker;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic [7:0] din;
    logic       locked;
    logic       fail;
    logic [7:0] err_cnt;
    logic [7:0] last_good;

    int n_tests;
    int n_fail;

    tt_micro_cnt_checker #(
        .WIDTH    (8),
        .LOCK_CNT (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .clr       (clr),
        .din       (din),
        .locked    (locked),
        .fail      (fail),
        .err_cnt   (err_cnt),
        .last_good (last_good)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         en;
        bit         clr;
        logic [7:0] din;
        bit         locked;
        bit         fail;
        logic [7:0] err;
        logic [7:0] lg;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input bit l, input bit f,
                           input logic [7:0] e, input logic [7:0] g);
        chk({tag, " locked"},    {7'd0, locked}, {7'd0, l});
        chk({tag, " fail"},      {7'd0, fail},   {7'd0, f});
        chk({tag, " err_cnt"},   err_cnt,        e);
        chk({tag, " last_good"}, last_good,      g);
    endtask

    // Drive inputs, take one active edge, sample 1 ns later.
    task automatic step(input bit e, input bit c, input logic [7:0] d);
        en  = e;
        clr = c;
        din = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] cur;
        int         exp_err;

        n_tests = 0;
        n_fail  = 0;
        en      = 1'b0;
        clr     = 1'b0;
        din     = 8'h00;
        rst_n   = 1'b0;

        // en din locked fail err last_good, applied in order from reset.
        // Lock on 0x10.. : en at E0, locked visible after E4.
        vecs.push_back('{1, 0, 8'h10, 0, 0, 8'd0, 8'h00});
        vecs.push_back('{1, 0, 8'h11, 0, 0, 8'd0, 8'h00});
        vecs.push_back('{1, 0, 8'h12, 0, 0, 8'd0, 8'h00});
        vecs.push_back('{1, 0, 8'h13, 0, 0, 8'd0, 8'h00});
        vecs.push_back('{1, 0, 8'h14, 1, 0, 8'd0, 8'h00});
        vecs.push_back('{1, 0, 8'h15, 1, 0, 8'd0, 8'h15});
        vecs.push_back('{1, 0, 8'h16, 1, 0, 8'd0, 8'h16});
        // Skip 0x17: pulse, count, drop lock; re-lock 4 edges later.
        vecs.push_back('{1, 0, 8'h18, 0, 1, 8'd1, 8'h16});
        vecs.push_back('{1, 0, 8'h19, 0, 0, 8'd1, 8'h16});
        vecs.push_back('{1, 0, 8'h1A, 0, 0, 8'd1, 8'h16});
        vecs.push_back('{1, 0, 8'h1B, 0, 0, 8'd1, 8'h16});
        vecs.push_back('{1, 0, 8'h1C, 1, 0, 8'd1, 8'h16});
        vecs.push_back('{1, 0, 8'h1D, 1, 0, 8'd1, 8'h1D});
        // Jump to 0xFB, re-lock at 0xFF, then wrap through 0x00, 0x01.
        vecs.push_back('{1, 0, 8'hFB, 0, 1, 8'd2, 8'h1D});
        vecs.push_back('{1, 0, 8'hFC, 0, 0, 8'd2, 8'h1D});
        vecs.push_back('{1, 0, 8'hFD, 0, 0, 8'd2, 8'h1D});
        vecs.push_back('{1, 0, 8'hFE, 0, 0, 8'd2, 8'h1D});
        vecs.push_back('{1, 0, 8'hFF, 1, 0, 8'd2, 8'h1D});
        vecs.push_back('{1, 0, 8'h00, 1, 0, 8'd2, 8'h00});
        vecs.push_back('{1, 0, 8'h01, 1, 0, 8'd2, 8'h01});
        // Constant bus: one counted mismatch from LOCK, then silent in SYNC.
        vecs.push_back('{1, 0, 8'h01, 0, 1, 8'd3, 8'h01});
        vecs.push_back('{1, 0, 8'h01, 0, 0, 8'd3, 8'h01});
        vecs.push_back('{1, 0, 8'h01, 0, 0, 8'd3, 8'h01});
        vecs.push_back('{1, 0, 8'h01, 0, 0, 8'd3, 8'h01});
        vecs.push_back('{1, 0, 8'h01, 0, 0, 8'd3, 8'h01});
        // Resume counting, re-lock, then drop en: IDLE, err/last_good held.
        vecs.push_back('{1, 0, 8'h02, 0, 0, 8'd3, 8'h01});
        vecs.push_back('{1, 0, 8'h03, 0, 0, 8'd3, 8'h01});
        vecs.push_back('{1, 0, 8'h04, 0, 0, 8'd3, 8'h01});
        vecs.push_back('{1, 0, 8'h05, 1, 0, 8'd3, 8'h01});
        vecs.push_back('{1, 0, 8'h06, 1, 0, 8'd3, 8'h06});
        vecs.push_back('{0, 0, 8'h07, 0, 0, 8'd3, 8'h06});
        vecs.push_back('{0, 0, 8'h50, 0, 0, 8'd3, 8'h06});
        vecs.push_back('{0, 1, 8'h50, 0, 0, 8'd0, 8'h06});
        // Fresh enable on a constant 0x55: never locks.
        vecs.push_back('{1, 0, 8'h55, 0, 0, 8'd0, 8'h06});
        vecs.push_back('{1, 0, 8'h55, 0, 0, 8'd0, 8'h06});
        vecs.push_back('{1, 0, 8'h55, 0, 0, 8'd0, 8'h06});
        vecs.push_back('{1, 0, 8'h55, 0, 0, 8'd0, 8'h06});
        vecs.push_back('{1, 0, 8'h55, 0, 0, 8'd0, 8'h06});
        vecs.push_back('{1, 0, 8'h55, 0, 0, 8'd0, 8'h06});
        vecs.push_back('{0, 0, 8'h55, 0, 0, 8'd0, 8'h06});

        // Reset state.
        #12;
        chk_all("reset", 0, 0, 8'd0, 8'h00);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_all("idle", 0, 0, 8'd0, 8'h00);

        foreach (vecs[i]) begin
            step(vecs[i].en, vecs[i].clr, vecs[i].din);
            chk_all($sformatf("vec%0d", i), vecs[i].locked, vecs[i].fail,
                    vecs[i].err, vecs[i].lg);
        end

        // Saturation: 300 mismatches, each after a fresh lock.
        cur = 8'h00;
        step(1, 0, cur);
        exp_err = 0;
        for (int k = 0; k < 300; k++) begin
            for (int j = 0; j < 4; j++) begin
                cur = cur + 8'd1;
                step(1, 0, cur);
            end
            if (locked !== 1'b1) begin
                n_tests++;
                n_fail++;
                $display("FAIL sat_lock%0d: got locked=%0b, expected 1", k, locked);
            end
            cur = cur + 8'd2;
            step(1, 0, cur);
            if (exp_err < 255) exp_err++;
            if (k % 25 == 0 || k >= 250) begin
                chk($sformatf("sat%0d err_cnt", k), err_cnt, 8'(exp_err));
                chk($sformatf("sat%0d fail", k), {7'd0, fail}, 8'd1);
            end
        end
        chk("sat final err_cnt", err_cnt, 8'd255);

        // Re-lock, then clr together with a mismatch: clr wins, fail pulses.
        for (int j = 0; j < 4; j++) begin
            cur = cur + 8'd1;
            step(1, 0, cur);
        end
        chk("clr pre locked", {7'd0, locked}, 8'd1);
        cur = cur + 8'd3;
        step(1, 1, cur);
        chk_all("clr+miss", 0, 1, 8'd0, last_good_exp(cur));

        // Re-lock, accept one match, then reset asynchronously mid-cycle.
        for (int j = 0; j < 4; j++) begin
            cur = cur + 8'd1;
            step(1, 0, cur);
        end
        cur = cur + 8'd1;
        step(1, 0, cur);
        chk_all("prereset", 1, 0, 8'd0, cur);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 8'd0, 8'h00);
        #10;
        rst_n = 1'b1;
        en    = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // last_good after the clr+mismatch step is the final good sample of the
    // preceding lock, which was not updated (the lock edge itself does not
    // load last_good). The bench tracks it from the saturation loop: the last
    // accepted value is the match right before the final saturating mismatch,
    // i.e. none within the re-lock run, so it is the value stored there.
    logic [7:0] lg_track;
    always @(posedge clk) begin
        if (locked && en && (din == dut_prev_plus1())) lg_track <= din;
    end

    // Independent bench-side copy of the previous sample.
    logic [7:0] tb_prev;
    always @(posedge clk) tb_prev <= din;

    function automatic logic [7:0] dut_prev_plus1();
        return tb_prev + 8'd1;
    endfunction

    function automatic logic [7:0] last_good_exp(input logic [7:0] unused_cur);
        return lg_track;
    endfunction

endmodule
